// File: rtl/score_keeper.sv
// Tic-tac-toe score keeper: X/O/draw tallies, BCD games-played count and inverted-nibble digit codes.
// Define SCORE_FLASH_EN to build in the winner-highlight flash outputs.
module score_keeper #(
  parameter int unsigned FLASH_LEN = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       result_valid,
  input  logic [1:0] result,
  input  logic       clear,
  output logic       result_ack,
  output logic [3:0] x_code,
  output logic [3:0] o_code,
  output logic [3:0] draw_code,
  output logic [3:0] games_tens_code,
  output logic [3:0] games_ones_code,
  output logic       flash_x,
  output logic       flash_o
);

  typedef enum logic [1:0] {IDLE, UPDATE, WAIT_LOW} state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] o;
    logic [3:0] d;
    logic [3:0] tens;
    logic [3:0] ones;
  } counts_t;

  state_t     state_q, state_d;
  logic [1:0] res_q, res_d;
  counts_t    cnt_q, cnt_d;
  counts_t    code_q, code_d;
  logic       ack_q, ack_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd9) ? v : v + 4'd1;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    if (clear) begin
      state_d = WAIT_LOW;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (result_valid) begin
            res_d   = result;
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          ack_d   = 1'b1;
          state_d = WAIT_LOW;
          case (res_q)
            2'b01:   cnt_d.x = sat_inc(cnt_q.x);
            2'b10:   cnt_d.o = sat_inc(cnt_q.o);
            2'b11:   cnt_d.d = sat_inc(cnt_q.d);
            default: ;
          endcase
          // Games count is BCD and sticks at 99.
          if (res_q != 2'b00 && !(cnt_q.tens == 4'd9 && cnt_q.ones == 4'd9)) begin
            if (cnt_q.ones == 4'd9) begin
              cnt_d.ones = 4'd0;
              cnt_d.tens = cnt_q.tens + 4'd1;
            end else begin
              cnt_d.ones = cnt_q.ones + 4'd1;
            end
          end
        end
        WAIT_LOW: begin
          if (!result_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    code_d = ~cnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments under the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= 2'b00;
      cnt_q   <= '0;
      code_q  <= '1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ack_q   <= ack_d;
    end
  end

  assign result_ack      = ack_q;
  assign x_code          = code_q.x;
  assign o_code          = code_q.o;
  assign draw_code       = code_q.d;
  assign games_tens_code = code_q.tens;
  assign games_ones_code = code_q.ones;

`ifdef SCORE_FLASH_EN
  localparam int unsigned FW = (FLASH_LEN > 1) ? $clog2(FLASH_LEN) : 1;
  localparam logic [FW-1:0] RELOAD = FW'(FLASH_LEN - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fx_q, fx_d, fo_q, fo_d;
  logic          win_x, win_o;

  // A win reloads the counter; the flag drops on the edge after it reaches zero.
  always_comb begin
    win_x  = (state_q == UPDATE) && !clear && (res_q == 2'b01);
    win_o  = (state_q == UPDATE) && !clear && (res_q == 2'b10);
    fx_d   = fx_q;
    fo_d   = fo_q;
    fcnt_d = fcnt_q;
    if (fx_q || fo_q) begin
      if (fcnt_q == '0) begin
        fx_d = 1'b0;
        fo_d = 1'b0;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
      end
    end
    if (clear) begin
      fx_d   = 1'b0;
      fo_d   = 1'b0;
      fcnt_d = '0;
    end else if (win_x) begin
      fx_d   = 1'b1;
      fo_d   = 1'b0;
      fcnt_d = RELOAD;
    end else if (win_o) begin
      fx_d   = 1'b0;
      fo_d   = 1'b1;
      fcnt_d = RELOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      fx_q   <= 1'b0;
      fo_q   <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      fx_q   <= fx_d;
      fo_q   <= fo_d;
    end
  end

  assign flash_x = fx_q;
  assign flash_o = fo_q;
`else
  assign flash_x = 1'b0;
  assign flash_o = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table plus scoreboard of expected codes per result_ack.
module tb_score_keeper;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] o;
    logic [3:0] d;
    logic [3:0] t;
    logic [3:0] g;
  } codes_t;

  typedef struct {
    logic [1:0] res;
    int         hold;
    codes_t     exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       result_valid = 1'b0;
  logic [1:0] result = 2'b00;
  logic       clear = 1'b0;
  logic       result_ack;
  logic [3:0] x_code, o_code, draw_code, games_tens_code, games_ones_code;
  logic       flash_x, flash_o;

  int     n_checks = 0;
  int     n_errs = 0;
  int     ack_total = 0;
  codes_t exp_q[$];
  int     m_x, m_o, m_d, m_g;
  vec_t   vecs[5];

  always #5 clk = ~clk;

  score_keeper #(.FLASH_LEN(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .result_valid    (result_valid),
    .result          (result),
    .clear           (clear),
    .result_ack      (result_ack),
    .x_code          (x_code),
    .o_code          (o_code),
    .draw_code       (draw_code),
    .games_tens_code (games_tens_code),
    .games_ones_code (games_ones_code),
    .flash_x         (flash_x),
    .flash_o         (flash_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] res, input int hold, input logic [3:0] x,
                              input logic [3:0] o, input logic [3:0] d, input logic [3:0] t,
                              input logic [3:0] g);
    vec_t v;
    v.res = res;
    v.hold = hold;
    v.exp = {x, o, d, t, g};
    return v;
  endfunction

  function automatic codes_t model_step(input logic [1:0] res);
    codes_t c;
    if (res != 2'b00 && m_g < 99) m_g++;
    if (res == 2'b01 && m_x < 9) m_x++;
    if (res == 2'b10 && m_o < 9) m_o++;
    if (res == 2'b11 && m_d < 9) m_d++;
    c.x = ~4'(m_x);
    c.o = ~4'(m_o);
    c.d = ~4'(m_d);
    c.t = ~4'(m_g / 10);
    c.g = ~4'(m_g % 10);
    return c;
  endfunction

  task automatic model_zero();
    m_x = 0; m_o = 0; m_d = 0; m_g = 0;
    exp_q.delete();
  endtask

  // Scoreboard: every result_ack must match the oldest expected code set.
  always @(negedge clk) begin : monitor
    codes_t e;
    if (result_ack === 1'b1) begin
      ack_total++;
      if (exp_q.size() == 0) begin
        check("spurious_ack", result_ack, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("x_code", x_code, e.x);
        check("o_code", o_code, e.o);
        check("draw_code", draw_code, e.d);
        check("games_tens_code", games_tens_code, e.t);
        check("games_ones_code", games_ones_code, e.g);
      end
`ifndef SCORE_FLASH_EN
      check("flash_tied_low", {flash_x, flash_o}, 2'b00);
`endif
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    result_valid = 1'b0;
    clear = 1'b0;
    result = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_x_code", x_code, 4'hF);
    check("rst_o_code", o_code, 4'hF);
    check("rst_draw_code", draw_code, 4'hF);
    check("rst_tens_code", games_tens_code, 4'hF);
    check("rst_ones_code", games_ones_code, 4'hF);
    check("rst_ack", result_ack, 1'b0);
    check("rst_flash", {flash_x, flash_o}, 2'b00);
    check("rst_pending_expect", exp_q.size(), 0);
    model_zero();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one result for 'hold' edges; expect exactly one ack, seen after the second edge.
  task automatic send(input logic [1:0] res, input int hold, input codes_t exp);
    int acks, ack_at;
    acks = 0;
    ack_at = -1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 result = res;
    result_valid = 1'b1;
    for (int c = 0; c < hold + 4; c++) begin
      @(posedge clk);
      #1 if (c == hold - 1) result_valid = 1'b0;
      @(negedge clk);
      if (result_ack === 1'b1) begin
        acks++;
        if (ack_at < 0) ack_at = c;
      end
    end
    check("ack_count", acks, 1);
    check("ack_latency", ack_at, 1);
  endtask

  initial begin
    int a, fx, fo;
    vecs[0] = mk(2'b01, 5, 4'hE, 4'hF, 4'hF, 4'hF, 4'hE);
    vecs[1] = mk(2'b10, 1, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD);
    vecs[2] = mk(2'b11, 2, 4'hE, 4'hE, 4'hE, 4'hF, 4'hC);
    vecs[3] = mk(2'b00, 3, 4'hE, 4'hE, 4'hE, 4'hF, 4'hC);
    vecs[4] = mk(2'b01, 1, 4'hD, 4'hE, 4'hE, 4'hF, 4'hB);

    do_reset();
    for (int i = 0; i < 5; i++) send(vecs[i].res, vecs[i].hold, vecs[i].exp);

    // Saturation of the X tally and of the games count.
    do_reset();
    for (int i = 0; i < 12; i++) send(2'b01, 1, model_step(2'b01));
    @(negedge clk);
    check("x_saturated", x_code, 4'b0110);
    check("games_tens_12", games_tens_code, 4'b1110);
    check("games_ones_12", games_ones_code, 4'b1101);
    for (int i = 0; i < 100; i++) send(2'b11, 1, model_step(2'b11));
    @(negedge clk);
    check("games_tens_99", games_tens_code, 4'b0110);
    check("games_ones_99", games_ones_code, 4'b0110);
    check("draw_saturated", draw_code, 4'b0110);

    // Clear on the same edge result_valid rises: nothing counts until a fresh rise.
    a = ack_total;
    @(posedge clk);
    #1 clear = 1'b1;
    result = 2'b01;
    result_valid = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("clear_no_ack", ack_total - a, 0);
    check("clear_x_code", x_code, 4'hF);
    check("clear_draw_code", draw_code, 4'hF);
    check("clear_tens_code", games_tens_code, 4'hF);
    check("clear_ones_code", games_ones_code, 4'hF);
    #1 result_valid = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    send(2'b01, 2, model_step(2'b01));

    // Clear arriving while UPDATE is pending suppresses the ack and the count.
    a = ack_total;
    @(posedge clk);
    #1 result = 2'b10;
    result_valid = 1'b1;
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    result_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("clear_update_no_ack", ack_total - a, 0);
    check("clear_update_o_code", o_code, 4'hF);
    check("clear_update_x_code", x_code, 4'hF);
    model_zero();

    // Reset during UPDATE discards the pending O win.
    a = ack_total;
    @(posedge clk);
    #1 result = 2'b10;
    result_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    result_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_update_no_ack", ack_total - a, 0);
    check("rst_update_o_code", o_code, 4'hF);
    model_zero();

    // Result already valid when reset releases is still taken.
    a = ack_total;
    reset = 1'b1;
    result = 2'b11;
    result_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model_step(2'b11));
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 result_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("release_high_acks", ack_total - a, 1);
    check("release_high_draw", draw_code, 4'hE);

`ifdef SCORE_FLASH_EN
    do_reset();
    // Single X win: flash_x high for exactly FLASH_LEN cycles, starting with the ack.
    fx = 0;
    exp_q.push_back(model_step(2'b01));
    @(posedge clk);
    #1 result = 2'b01;
    result_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (c == 0) result_valid = 1'b0;
      @(negedge clk);
      if (flash_x === 1'b1) fx++;
      if (result_ack === 1'b1) check("flash_x_with_ack", flash_x, 1'b1);
    end
    check("flash_x_len", fx, 4);

    // O win arriving while X is flashing switches the highlight and restarts the count.
    fx = 0;
    fo = 0;
    exp_q.push_back(model_step(2'b01));
    @(posedge clk);
    #1 result = 2'b01;
    result_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 if (c == 0) result_valid = 1'b0;
      if (c == 2) begin
        exp_q.push_back(model_step(2'b10));
        result = 2'b10;
        result_valid = 1'b1;
      end
      if (c == 3) result_valid = 1'b0;
      @(negedge clk);
      if (c == 3) check("flash_x_before_switch", flash_x, 1'b1);
      if (c == 4) check("switch_ack", result_ack, 1'b1);
      if (c >= 4 && flash_x === 1'b1) fx++;
      if (c >= 4 && flash_o === 1'b1) fo++;
    end
    check("flash_x_after_switch", fx, 0);
    check("flash_o_len", fo, 4);
`else
    @(negedge clk);
    check("flash_disabled", {flash_x, flash_o}, 2'b00);
`endif

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter FLASH_LEN, default 25000000, cycles a flash output stays high after a win.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port result_valid  input  1  level from game FSM; held high while result is presented.
REQ-005 SHALL have port result  input  2  00 none, 01 X win, 10 O win, 11 draw.
REQ-006 SHALL have port clear  input  1  synchronous score clear, one-cycle or longer.
REQ-007 SHALL have port result_ack  output  1  one-cycle pulse when a result is consumed.
REQ-008 SHALL have ports x_code, o_code, draw_code  output  4 each  inverted-nibble digit codes for seven-segment drivers.
REQ-009 SHALL have ports games_tens_code, games_ones_code  output  4 each  inverted-nibble games-played digits.
REQ-010 SHALL have ports flash_x, flash_o  output  1 each  winner highlight.

Function
REQ-011 SHALL encode every digit output as bitwise NOT of its value (value 0 -> 4'b1111, value 9 -> 4'b0110), registered.
REQ-012 SHALL implement states IDLE, UPDATE, WAIT_LOW.
REQ-013 SHALL, in IDLE with result_valid high, latch result and go to UPDATE.
REQ-014 SHALL, in UPDATE, apply the latched result, pulse result_ack for exactly that next cycle, and go to WAIT_LOW.
REQ-015 SHALL, in WAIT_LOW, stay until result_valid low, then return to IDLE; one held level counts once.
REQ-016 SHALL make updated codes visible in the same cycle result_ack is high (2 clocks after result_valid first sampled high).
REQ-017 SHALL increment x, o, or draw count (0..9) per result 01/10/11, saturating at 9.
REQ-018 SHALL increment games count (BCD 00..99) for results 01/10/11, saturating at 99; ones digit wraps 9->0 with tens carry.
REQ-019 SHALL, for latched result 00, pulse result_ack with no count change.
REQ-020 SHALL, on clear, zero all counts, drop flash outputs, suppress any pending update and result_ack, and enter WAIT_LOW.
REQ-021 SHALL give clear priority over a simultaneous result_valid or UPDATE.

Reset
REQ-022 SHALL, on reset high, asynchronously set state IDLE, all counts 0 (every code 4'b1111), result_ack 0, flash_x 0, flash_o 0, flash counter 0.
REQ-023 SHALL, when reset is asserted mid-UPDATE, discard the pending result; no result_ack after release.
REQ-024 SHALL, after reset release with result_valid already high, accept that result (IDLE samples it).

Configuration
REQ-025 SHALL use macro SCORE_FLASH_EN to compile the flash logic in or out.
REQ-026 SHALL, with SCORE_FLASH_EN defined, raise flash_x (flash_o) in the cycle result_ack marks an X (O) win and hold it exactly FLASH_LEN cycles.
REQ-027 SHALL, with SCORE_FLASH_EN defined, restart the count on a repeat win by the same player, switch flash to the new winner on an opposing win, leave flash unchanged on a draw or 00, and still flash at saturation.
REQ-028 SHALL, without SCORE_FLASH_EN, tie flash_x and flash_o to 0 and include no flash counter.

Verification
REQ-029 SHALL cover: reset -> all five codes 4'b1111, result_ack 0, flash 0.
REQ-030 SHALL cover: result=01 with result_valid held 5 cycles -> one result_ack, 2 clocks after first high; x_code 4'b1110, games_ones_code 4'b1110.
REQ-031 SHALL cover: 12 X wins -> x_code saturates at 4'b0110; games digits 1,2 (tens 4'b1110, ones 4'b1101); 100 draws -> games stuck at 99 (4'b0110, 4'b0110).
REQ-032 SHALL cover: clear on the same edge result_valid rises -> no result_ack, codes 4'b1111, no count until result_valid drops and rises again.
REQ-033 SHALL cover, with SCORE_FLASH_EN and FLASH_LEN=4: X win -> flash_x high exactly 4 cycles; O win 2 cycles into X flash -> flash_x low, flash_o high 4 cycles; without macro -> flash_x and flash_o always 0.
REQ-034 SHALL cover: reset asserted in UPDATE with result=10 -> o_code stays 4'b1111, no result_ack after release.
